// File: rtl/abro_pkg.sv
// Shared state encoding and output decode for the N-event ABRO controller.
package abro_pkg;

    typedef enum logic [1:0] {
        ST_WAIT = 2'b00,
        ST_FIRE = 2'b01,
        ST_DONE = 2'b10,
        ST_BAD  = 2'b11
    } abro_state_t;

    // Pulse mode drives o only in FIRE; level mode holds it through DONE.
    function automatic logic abro_o_decode(input abro_state_t s, input logic pulse);
        if (pulse)
            return (s == ST_FIRE);
        else
            return (s == ST_FIRE) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/abro_seen_tracker.sv
// Sticky N-bit OR-accumulator of observed events, with clear and enable.
module abro_seen_tracker #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         en,
    input  logic [N-1:0] ev,
    output logic [N-1:0] seen,
    output logic         all_seen
);

    // Looks ahead at this cycle's events so completion is taken on the same edge.
    assign all_seen = &(seen | ev);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            seen <= '0;
        else if (clr)
            seen <= '0;
        else if (en)
            seen <= seen | ev;
    end

endmodule

// File: rtl/abro_n_sm.sv
// N-event ABRO controller: fires once all events are seen, blocks until restart r.
module abro_n_sm
    import abro_pkg::*;
#(
    parameter int N       = 2,
    parameter int PULSE_O = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             r,
    input  logic [N-1:0]     ev,
    output logic             o,
    output logic [N-1:0]     seen,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] done_count
);

    abro_state_t state_q, state_d;
    logic        clr, en, inc, all_seen;

    abro_seen_tracker #(.N(N)) u_seen (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (clr),
        .en       (en),
        .ev       (ev),
        .seen     (seen),
        .all_seen (all_seen)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= ST_WAIT;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        en      = 1'b0;
        inc     = 1'b0;
        if (r) begin
            state_d = ST_WAIT;
            clr     = 1'b1;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    en = 1'b1;
                    if (all_seen) begin
                        state_d = ST_FIRE;
                        inc     = 1'b1;
                    end
                end
                ST_FIRE: state_d = ST_DONE;
                ST_DONE: state_d = ST_DONE;
                ST_BAD: begin
                    state_d = ST_WAIT;
                    clr     = 1'b1;
                end
                default: begin
                    state_d = ST_WAIT;
                    clr     = 1'b1;
                end
            endcase
        end
    end

    // Completion count survives r; only reset_n clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            done_count <= '0;
        else if (inc && (done_count != {CNT_W{1'b1}}))
            done_count <= done_count + 1'b1;
    end

    assign state = state_q;
    assign o     = abro_o_decode(state_q, PULSE_O != 0);

endmodule

// File: tb/tb_abro_n_sm.sv
// Scoreboard bench: three abro_n_sm variants driven in lockstep against a set-based reference.
module tb_abro_n_sm;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       r = 1'b0;
    logic [3:0] ev = '0;

    always #5 clk = ~clk;

    // d0: N=4 level mode; d1: N=4 pulse mode, 2-bit counter; d2: N=1 pulse mode, 3-bit counter
    logic       o0, o1, o2;
    logic [3:0] seen0, seen1;
    logic       seen2;
    logic [1:0] st0, st1, st2;
    logic [7:0] cnt0;
    logic [1:0] cnt1;
    logic [2:0] cnt2;

    abro_n_sm #(.N(4), .PULSE_O(0), .CNT_W(8)) d0 (
        .clk(clk), .reset_n(reset_n), .r(r), .ev(ev),
        .o(o0), .seen(seen0), .state(st0), .done_count(cnt0));
    abro_n_sm #(.N(4), .PULSE_O(1), .CNT_W(2)) d1 (
        .clk(clk), .reset_n(reset_n), .r(r), .ev(ev),
        .o(o1), .seen(seen1), .state(st1), .done_count(cnt1));
    abro_n_sm #(.N(1), .PULSE_O(1), .CNT_W(3)) d2 (
        .clk(clk), .reset_n(reset_n), .r(r), .ev(ev[0:0]),
        .o(o2), .seen(seen2), .state(st2), .done_count(cnt2));

    typedef struct packed {
        logic [2:0][1:0] st;
        logic [2:0][3:0] seen;
        logic [2:0]      o;
        logic [2:0][7:0] cnt;
    } obs_t;

    obs_t act;
    assign act.st   = {st2, st1, st0};
    assign act.seen = {{3'b000, seen2}, seen1, seen0};
    assign act.o    = {o2, o1, o0};
    assign act.cnt  = {{5'b0, cnt2}, {6'b0, cnt1}, cnt0};

    int n_tests = 0;
    int n_fail  = 0;
    obs_t exp_q[$];

    // Reference: a set of seen events, a "completed" flag and the age of the completion.
    localparam logic [3:0] MASK [3] = '{4'hF, 4'hF, 4'h1};
    localparam int         CMAX [3] = '{255, 3, 7};
    localparam bit         PULS [3] = '{1'b0, 1'b1, 1'b1};
    logic [3:0] m_seen [3];
    bit         m_done [3];
    bit         m_fresh[3];
    int         m_cnt  [3];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_seen[k] = '0; m_done[k] = 0; m_fresh[k] = 0; m_cnt[k] = 0;
        end
    endtask

    task automatic model_edge(input logic rr, input logic [3:0] e);
        for (int k = 0; k < 3; k++) begin
            if (rr) begin
                m_seen[k] = '0; m_done[k] = 0; m_fresh[k] = 0;
            end else if (m_done[k]) begin
                m_fresh[k] = 0;
            end else begin
                m_seen[k] = m_seen[k] | (e & MASK[k]);
                if (m_seen[k] == MASK[k]) begin
                    m_done[k] = 1; m_fresh[k] = 1;
                    if (m_cnt[k] < CMAX[k]) m_cnt[k]++;
                end
            end
        end
    endtask

    function automatic obs_t model_obs();
        obs_t x;
        for (int k = 0; k < 3; k++) begin
            x.st[k]   = !m_done[k] ? 2'b00 : (m_fresh[k] ? 2'b01 : 2'b10);
            x.seen[k] = m_seen[k];
            x.o[k]    = m_fresh[k] || (m_done[k] && !PULS[k]);
            x.cnt[k]  = m_cnt[k][7:0];
        end
        return x;
    endfunction

    task automatic chk(input string name, input int k, input logic [7:0] a, input logic [7:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s[d%0d] at %0t: got %0h expected %0h", name, k, $time, a, e);
        end
    endtask

    task automatic chk_all(input obs_t a, input obs_t e);
        for (int k = 0; k < 3; k++) begin
            chk("state", k, {6'b0, a.st[k]}, {6'b0, e.st[k]});
            chk("seen",  k, {4'b0, a.seen[k]}, {4'b0, e.seen[k]});
            chk("o",     k, {7'b0, a.o[k]}, {7'b0, e.o[k]});
            chk("count", k, a.cnt[k], e.cnt[k]);
        end
    endtask

    // Monitor: the outputs are valid every cycle, so each edge retires one expectation.
    always @(posedge clk) begin
        obs_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk_all(act, e);
        end
    end

    task automatic step(input logic rr, input logic [3:0] e);
        @(negedge clk);
        r  = rr;
        ev = e;
        model_edge(rr, e);
        exp_q.push_back(model_obs());
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk_all(act, model_obs());
        r  = 1'b0;
        ev = '0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        chk_all(act, model_obs());
        @(negedge clk);
        reset_n = 1'b1;

        // Incremental collection, then DONE hold with ignored events.
        step(0, 4'b0001); step(0, 4'b0010); step(0, 4'b0100); step(0, 4'b1000);
        step(0, 4'b0000); step(0, 4'b1010); step(0, 4'b0101);
        step(0, 4'b0000); step(0, 4'b0000); step(0, 4'b0000);
        step(1, 4'b0000);
        // Everything in one cycle, then restart while in FIRE.
        step(0, 4'b1111); step(1, 4'b1111);
        // Restart colliding with the final event, then redo.
        step(0, 4'b0011); step(0, 4'b0100); step(1, 4'b1000);
        step(0, 4'b0111); step(0, 4'b1000); step(0, 4'b0000);
        // Back-to-back completions to drive the 2-bit counter into saturation.
        for (int i = 0; i < 5; i++) begin
            step(1, 4'b0000); step(0, 4'b1111); step(0, 4'b0000);
        end
        // Asynchronous reset while in DONE.
        step(0, 4'b0000);
        async_reset();
        step(0, 4'b1100); step(0, 4'b0011); step(0, 4'b0000);

        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 7) == 0), 4'($urandom));
        step(0, 4'b0000);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++)
            @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
